// File: rtl/dma_pkg.sv
// Shared types and constants for the word-granular copy engine.
package dma_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned OFS_W  = 2;

  // Copy sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_e;

  // Register index taken from address bits [3:2].
  localparam logic [OFS_W-1:0] REG_SRC  = 2'd0;
  localparam logic [OFS_W-1:0] REG_DST  = 2'd1;
  localparam logic [OFS_W-1:0] REG_LEN  = 2'd2;
  localparam logic [OFS_W-1:0] REG_CTRL = 2'd3;

  // CTRL/STAT bit positions.
  localparam int unsigned CTRL_START = 0;
  localparam int unsigned STAT_BUSY  = 1;
  localparam int unsigned CTRL_DONE  = 2;
  localparam int unsigned CTRL_ERR   = 3;
  localparam int unsigned CTRL_IE    = 4;

  // Replace only the bytes whose write strobe is set.
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_v,
                                                   input logic [DATA_W-1:0] new_v,
                                                   input logic [MASK_W-1:0] mask);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      if (mask[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dma_regs.sv
// Slave register window: SRC/DST/LEN/CTRL storage, status, interrupt.
module dma_regs
  import dma_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OFS_W-1:0]     reg_sel_i,
  input  logic                 sel_i,
  input  logic                 read_i,
  input  logic [MASK_W-1:0]    wmask_i,
  input  logic [DATA_W-1:0]    wdata_i,
  output logic [DATA_W-1:0]    rdata_o,
  input  logic                 busy_i,
  input  logic                 rd_ok_i,
  input  logic                 wr_ok_i,
  input  logic                 fault_i,
  output logic                 start_o,
  output logic [DATA_W-1:0]    src_o,
  output logic [DATA_W-1:0]    dst_o,
  output logic [LEN_WIDTH-1:0] len_o,
  output logic                 irq_o
);

  logic [DATA_W-1:0]    src_q, src_d;
  logic [DATA_W-1:0]    dst_q, dst_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 ie_q, ie_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 irq_q, irq_d;
  logic                 wr_en;
  logic [DATA_W-1:0]    merged;

  // Register update: bus writes first, engine events override.
  always_comb begin
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    ie_d    = ie_q;
    done_d  = done_q;
    err_d   = err_q;
    wr_en   = sel_i & (|wmask_i);
    merged  = '0;
    start_o = sel_i & wmask_i[0] & (reg_sel_i == REG_CTRL) & wdata_i[CTRL_START] & ~busy_i;

    if (wr_en && !busy_i) begin
      unique case (reg_sel_i)
        REG_SRC: begin
          merged = byte_merge(src_q, wdata_i, wmask_i);
          src_d  = {merged[DATA_W-1:2], 2'b00};
        end
        REG_DST: begin
          merged = byte_merge(dst_q, wdata_i, wmask_i);
          dst_d  = {merged[DATA_W-1:2], 2'b00};
        end
        REG_LEN: begin
          merged = byte_merge(DATA_W'(len_q), wdata_i, wmask_i);
          len_d  = LEN_WIDTH'(merged);
        end
        default: ;
      endcase
    end

    if (wr_en && (reg_sel_i == REG_CTRL) && wmask_i[0]) begin
      ie_d = wdata_i[CTRL_IE];
      if (wdata_i[CTRL_DONE]) done_d = 1'b0;
      if (wdata_i[CTRL_ERR])  err_d  = 1'b0;
    end

    if (start_o) begin
      err_d  = 1'b0;
      done_d = (len_q == '0);
    end

    if (rd_ok_i) src_d = src_q + DATA_W'(4);

    if (wr_ok_i) begin
      dst_d = dst_q + DATA_W'(4);
      len_d = len_q - LEN_WIDTH'(1);
      if (len_q == LEN_WIDTH'(1)) done_d = 1'b1;
    end

    if (fault_i) err_d = 1'b1;

    irq_d = (done_d | err_d) & ie_d;
  end

  // Register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      ie_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      src_q  <= src_d;
      dst_q  <= dst_d;
      len_q  <= len_d;
      ie_q   <= ie_d;
      done_q <= done_d;
      err_q  <= err_d;
      irq_q  <= irq_d;
    end
  end

  // Combinational read mux, zero when not selected (OR-combined bus).
  always_comb begin
    rdata_o = '0;
    if (sel_i && read_i) begin
      unique case (reg_sel_i)
        REG_SRC:  rdata_o = src_q;
        REG_DST:  rdata_o = dst_q;
        REG_LEN:  rdata_o = DATA_W'(len_q);
        REG_CTRL: begin
          rdata_o[STAT_BUSY] = busy_i;
          rdata_o[CTRL_DONE] = done_q;
          rdata_o[CTRL_ERR]  = err_q;
          rdata_o[CTRL_IE]   = ie_q;
        end
        default: ;
      endcase
    end
  end

  assign src_o = src_q;
  assign dst_o = dst_q;
  assign len_o = len_q;
  assign irq_o = irq_q;

endmodule

// File: rtl/dma_copy.sv
// Memory-to-memory copy engine: register window plus read/write sequencer.
module dma_copy
  import dma_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] address_in,
  input  logic              sel_in,
  input  logic              read_in,
  output logic [DATA_W-1:0] read_value_out,
  input  logic [MASK_W-1:0] write_mask_in,
  input  logic [DATA_W-1:0] write_value_in,
  output logic              ready_out,
  output logic [DATA_W-1:0] m_address_out,
  output logic              m_read_out,
  output logic              m_write_out,
  input  logic [DATA_W-1:0] m_read_value_in,
  output logic [MASK_W-1:0] m_write_mask_out,
  output logic [DATA_W-1:0] m_write_value_out,
  input  logic              m_ready_in,
  input  logic              m_fault_in,
  output logic              irq_out
);

  state_e               state_q, state_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 start, busy, rd_ok, wr_ok, fault_evt;
  logic [DATA_W-1:0]    src, dst;
  logic [LEN_WIDTH-1:0] len;
  logic                 addr_unused;

  assign addr_unused = ^{address_in[DATA_W-1:4], address_in[1:0]};
  assign busy        = (state_q != IDLE);
  assign ready_out   = sel_in;

  dma_regs #(
    .LEN_WIDTH(LEN_WIDTH)
  ) u_regs (
    .clk       (clk),
    .rst_n     (reset_n),
    .reg_sel_i (address_in[3:2]),
    .sel_i     (sel_in),
    .read_i    (read_in),
    .wmask_i   (write_mask_in),
    .wdata_i   (write_value_in),
    .rdata_o   (read_value_out),
    .busy_i    (busy),
    .rd_ok_i   (rd_ok),
    .wr_ok_i   (wr_ok),
    .fault_i   (fault_evt),
    .start_o   (start),
    .src_o     (src),
    .dst_o     (dst),
    .len_o     (len),
    .irq_o     (irq_out)
  );

  // Sequencer state and latched read word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state and master-port drive; fault outranks ready.
  always_comb begin
    state_d           = state_q;
    rdata_d           = rdata_q;
    rd_ok             = 1'b0;
    wr_ok             = 1'b0;
    fault_evt         = 1'b0;
    m_address_out     = '0;
    m_read_out        = 1'b0;
    m_write_out       = 1'b0;
    m_write_mask_out  = '0;
    m_write_value_out = '0;

    unique case (state_q)
      IDLE: begin
        if (start && (len != '0)) state_d = RD;
      end
      RD: begin
        m_read_out    = 1'b1;
        m_address_out = src;
        if (m_fault_in) begin
          fault_evt = 1'b1;
          state_d   = IDLE;
        end else if (m_ready_in) begin
          rd_ok   = 1'b1;
          rdata_d = m_read_value_in;
          state_d = WR;
        end
      end
      WR: begin
        m_write_out       = 1'b1;
        m_address_out     = dst;
        m_write_mask_out  = {MASK_W{1'b1}};
        m_write_value_out = rdata_q;
        if (m_fault_in) begin
          fault_evt = 1'b1;
          state_d   = IDLE;
        end else if (m_ready_in) begin
          wr_ok   = 1'b1;
          state_d = (len == LEN_WIDTH'(1)) ? IDLE : RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_copy.sv
// Directed bench for dma_copy with a RAM responder and a write scoreboard.
module tb_dma_copy;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] address_in = '0;
  logic        sel_in = 1'b0;
  logic        read_in = 1'b0;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in = '0;
  logic [31:0] write_value_in = '0;
  logic        ready_out;
  logic [31:0] m_address_out;
  logic        m_read_out;
  logic        m_write_out;
  logic [31:0] m_read_value_in = '0;
  logic [3:0]  m_write_mask_out;
  logic [31:0] m_write_value_out;
  logic        m_ready_in = 1'b0;
  logic        m_fault_in = 1'b0;
  logic        irq_out;

  always #5 clk = ~clk;

  dma_copy #(.LEN_WIDTH(16)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .address_in        (address_in),
    .sel_in            (sel_in),
    .read_in           (read_in),
    .read_value_out    (read_value_out),
    .write_mask_in     (write_mask_in),
    .write_value_in    (write_value_in),
    .ready_out         (ready_out),
    .m_address_out     (m_address_out),
    .m_read_out        (m_read_out),
    .m_write_out       (m_write_out),
    .m_read_value_in   (m_read_value_in),
    .m_write_mask_out  (m_write_mask_out),
    .m_write_value_out (m_write_value_out),
    .m_ready_in        (m_ready_in),
    .m_fault_in        (m_fault_in),
    .irq_out           (irq_out)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  logic [31:0] mem [0:255];
  exp_t        exp_q[$];
  exp_t        e;
  bit          wait_mode = 1'b0;
  int          fault_read_n = 0;
  int          reads_done = 0;
  int          txns = 0;
  int          req_cycles = 0;
  int          wait_left = 0;
  bit          pending = 1'b0;
  logic [31:0] held_addr = '0;
  logic        held_rd = 1'b0;
  logic [31:0] held_wdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  // RAM responder: decides the handshake for the coming edge, checks holds and writes.
  always @(negedge clk) begin
    m_ready_in = 1'b0;
    m_fault_in = 1'b0;
    if (!reset_n) begin
      pending   = 1'b0;
      wait_left = 0;
    end else if (m_read_out || m_write_out) begin
      req_cycles++;
      chk("rd_wr_excl", 32'(m_read_out & m_write_out), 32'd0);
      if (pending) begin
        chk("hold_addr", m_address_out, held_addr);
        chk("hold_op", 32'(m_read_out), 32'(held_rd));
        if (!held_rd) chk("hold_wdata", m_write_value_out, held_wdata);
      end else begin
        pending    = 1'b1;
        held_addr  = m_address_out;
        held_rd    = m_read_out;
        held_wdata = m_write_value_out;
      end
      if (wait_left > 0) begin
        wait_left--;
      end else begin
        m_ready_in = 1'b1;
        pending    = 1'b0;
        wait_left  = wait_mode ? int'($urandom_range(3, 0)) : 0;
        if (m_read_out) begin
          reads_done++;
          if (reads_done == fault_read_n) begin
            m_fault_in      = 1'b1;
            m_read_value_in = 32'hBAD0BAD0;
          end else begin
            m_read_value_in = mem[m_address_out[9:2]];
            txns++;
          end
        end else begin
          txns++;
          chk("wr_mask", 32'(m_write_mask_out), 32'h0000000F);
          if (exp_q.size() == 0) begin
            chk("wr_unexpected", m_address_out, 32'hFFFFFFFF);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", m_address_out, e.addr);
            chk("wr_data", m_write_value_out, e.data);
          end
          mem[m_address_out[9:2]] = m_write_value_out;
        end
      end
    end
  end

  task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    address_in     = a;
    sel_in         = 1'b1;
    read_in        = 1'b0;
    write_mask_in  = 4'hF;
    write_value_in = d;
    @(negedge clk);
    sel_in         = 1'b0;
    write_mask_in  = 4'h0;
  endtask

  task automatic reg_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    address_in = a;
    sel_in     = 1'b1;
    read_in    = 1'b1;
    #1;
    d          = read_value_out;
    sel_in     = 1'b0;
    read_in    = 1'b0;
  endtask

  task automatic wait_idle(output logic [31:0] s);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      reg_read(32'hC, s);
      if (!s[1]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  // Program a copy and queue the writes expected for the first nexp words.
  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst,
                          input int len, input int nexp);
    exp_t x;
    reg_write(32'h0, src);
    reg_write(32'h4, dst);
    reg_write(32'h8, 32'(len));
    for (int i = 0; i < nexp; i++) begin
      x.addr = dst + 32'(4 * i);
      x.data = mem[(src[9:2] + 8'(i))];
      exp_q.push_back(x);
    end
    txns = 0;
    reg_write(32'hC, 32'h1);
  endtask

  logic [31:0] rv;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 + 32'(i * 32'h00010101);

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_irq", 32'(irq_out), 32'd0);
    chk("rst_mreq", 32'({m_read_out, m_write_out}), 32'd0);
    reset_n = 1'b1;
    reg_read(32'h0, rv); chk("rst_src", rv, 32'h0);
    reg_read(32'h4, rv); chk("rst_dst", rv, 32'h0);
    reg_read(32'h8, rv); chk("rst_len", rv, 32'h0);
    reg_read(32'hC, rv); chk("rst_stat", rv, 32'h0);
    chk("ready_follows_sel", 32'(ready_out), 32'd0);

    // Zero-wait copy of four words.
    run_copy(32'h100, 32'h200, 4, 4);
    wait_idle(rv);
    chk("t1_stat", rv, 32'h4);
    chk("t1_txns", 32'(txns), 32'd8);
    reg_read(32'h0, rv); chk("t1_src", rv, 32'h110);
    reg_read(32'h4, rv); chk("t1_dst", rv, 32'h210);
    reg_read(32'h8, rv); chk("t1_len", rv, 32'h0);
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t1_irq", 32'(irq_out), 32'd0);

    // Same copy with random wait states.
    for (int i = 0; i < 4; i++) mem[(32'h200 >> 2) + i] = 32'h0;
    wait_mode = 1'b1;
    run_copy(32'h100, 32'h200, 4, 4);
    wait_idle(rv);
    wait_mode = 1'b0;
    chk("t2_stat", rv, 32'h4);
    chk("t2_txns", 32'(txns), 32'd8);
    reg_read(32'h0, rv); chk("t2_src", rv, 32'h110);
    reg_read(32'h8, rv); chk("t2_len", rv, 32'h0);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t2_mem3", mem[(32'h20C >> 2)], mem[(32'h10C >> 2)]);

    // LEN=0 start: immediate DONE, no bus traffic, interrupt with IE.
    reg_write(32'hC, 32'h4);
    reg_read(32'hC, rv); chk("t3_clear", rv, 32'h0);
    reg_write(32'h8, 32'h0);
    req_cycles = 0;
    chk("t3_irq_before", 32'(irq_out), 32'd0);
    reg_write(32'hC, 32'h11);
    chk("t3_irq", 32'(irq_out), 32'd1);
    reg_read(32'hC, rv); chk("t3_stat", rv, 32'h14);
    repeat (5) @(negedge clk);
    chk("t3_no_bus", 32'(req_cycles), 32'd0);
    reg_write(32'hC, 32'h14);
    reg_read(32'hC, rv); chk("t3_ack", rv, 32'h10);
    chk("t3_irq_off", 32'(irq_out), 32'd0);
    reg_write(32'hC, 32'h0);

    // Fault on the second read.
    reads_done   = 0;
    fault_read_n = 2;
    run_copy(32'h100, 32'h200, 4, 1);
    wait_idle(rv);
    fault_read_n = 0;
    chk("t4_stat", rv, 32'h8);
    reg_read(32'h0, rv); chk("t4_src", rv, 32'h104);
    reg_read(32'h4, rv); chk("t4_dst", rv, 32'h204);
    reg_read(32'h8, rv); chk("t4_len", rv, 32'h3);
    chk("t4_txns", 32'(txns), 32'd2);
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);
    reg_write(32'hC, 32'h8);
    reg_read(32'hC, rv); chk("t4_err_clr", rv, 32'h0);

    // Register writes and START while busy are ignored.
    run_copy(32'h100, 32'h280, 4, 4);
    reg_read(32'hC, rv); chk("t5_busy", rv & 32'h2, 32'h2);
    reg_write(32'h0, 32'hDEAD0000);
    reg_write(32'hC, 32'h1);
    wait_idle(rv);
    chk("t5_stat", rv, 32'h4);
    chk("t5_txns", 32'(txns), 32'd8);
    reg_read(32'h0, rv); chk("t5_src", rv, 32'h110);
    reg_read(32'h4, rv); chk("t5_dst", rv, 32'h290);
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a write.
    reg_write(32'hC, 32'h10);
    wait_mode = 1'b1;
    run_copy(32'h100, 32'h300, 4, 4);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (m_write_out) begin
          seen = 1'b1;
          break;
        end
      end
      chk("t6_saw_write", 32'(seen), 32'd1);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("t6_ctl_zero", 32'({m_read_out, m_write_out, m_write_mask_out, irq_out}), 32'd0);
    chk("t6_addr_zero", m_address_out, 32'h0);
    chk("t6_wval_zero", m_write_value_out, 32'h0);
    exp_q.delete();
    wait_mode = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    reg_read(32'hC, rv); chk("t6_stat", rv, 32'h0);
    reg_read(32'h0, rv); chk("t6_src", rv, 32'h0);
    reg_read(32'h8, rv); chk("t6_len", rv, 32'h0);
    repeat (3) @(negedge clk);
    chk("t6_idle", 32'({m_read_out, m_write_out}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
